// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if -- control and status bundle between the decode stage and
// the program-counter sequencer.
//
//   master (decode side) drives: Stall, Exc, BrTaken, BrOffset, JumpEn,
//                                Addr26, LinkEn, JrEn, JrTarget, RetEn
//   slave  (sequencer)   drives: PC, PCPlus4, PCPlus8, RasTop, RasEmpty,
//                                RasOverflow, RetMiss
interface pc_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Stall;
  logic             Exc;
  logic             BrTaken;
  logic [WIDTH-1:0] BrOffset;
  logic             JumpEn;
  logic [25:0]      Addr26;
  logic             LinkEn;
  logic             JrEn;
  logic [WIDTH-1:0] JrTarget;
  logic             RetEn;

  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] PCPlus4;
  logic [WIDTH-1:0] PCPlus8;
  logic [WIDTH-1:0] RasTop;
  logic             RasEmpty;
  logic             RasOverflow;
  logic             RetMiss;

  modport master (
    output Stall, Exc, BrTaken, BrOffset, JumpEn, Addr26, LinkEn,
           JrEn, JrTarget, RetEn,
    input  PC, PCPlus4, PCPlus8, RasTop, RasEmpty, RasOverflow, RetMiss
  );

  modport slave (
    input  Stall, Exc, BrTaken, BrOffset, JumpEn, Addr26, LinkEn,
           JrEn, JrTarget, RetEn,
    output PC, PCPlus4, PCPlus8, RasTop, RasEmpty, RasOverflow, RetMiss
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer -- program counter with next-PC selection and a circular
// return-address stack (RAS) for call/return prediction.
//
// Ports:
//   CLK    in   rising-edge clock
//   Reset  in   asynchronous, active-low reset
//   bus    slave modport of pc_sequencer_if:
//            Stall     hold PC/RAS/RetMiss (Exc still redirects)
//            Exc       redirect to EXC_VECTOR, no RAS activity
//            BrTaken   PC+4 + (BrOffset<<2)
//            JumpEn    J-type jump to {PCPlus4[hi], Addr26, 2'b00}
//            LinkEn    with JumpEn: push PC+8 on the RAS
//            JrEn      register jump to JrTarget
//            RetEn     with JrEn: pop the RAS and use its top as target
//            PC        registered program counter
//            PCPlus4/8 combinational PC+4 / PC+8
//            RasTop    top-of-stack (0 when empty)
//            RasEmpty  stack holds no entries
//            RasOverflow sticky: a push overwrote the oldest entry
//            RetMiss   one-cycle pulse after a mispredicted/empty pop
module pc_sequencer #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_4180),
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input logic           CLK,
  input logic           Reset,
  pc_sequencer_if.slave bus
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(RAS_DEPTH);
  // Bits above the 28-bit J-type region are kept from PC+4.
  localparam logic [WIDTH-1:0] HI_MASK = ~(WIDTH'(28'hFFF_FFFF));

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] stack [RAS_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             ovf_q;
  logic             retmiss_q;

  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] pc_plus8;
  logic [PW-1:0]    top_idx;
  logic             ras_empty;
  logic             ras_full;
  logic [WIDTH-1:0] ras_top;
  logic [WIDTH-1:0] jump_tgt;
  logic [WIDTH-1:0] br_tgt;
  logic [WIDTH-1:0] jr_tgt;
  logic [WIDTH-1:0] next_pc;
  logic             advance;
  logic             do_push;
  logic             do_pop;
  logic             pop_miss;

  always_comb begin
    pc_plus4  = pc_q + WIDTH'(4);
    pc_plus8  = pc_q + WIDTH'(8);
    top_idx   = wr_ptr - PW'(1);
    ras_empty = (count == '0);
    ras_full  = (count == FULL_COUNT);
    ras_top   = ras_empty ? '0 : stack[top_idx];
    jump_tgt  = (pc_plus4 & HI_MASK) | WIDTH'({bus.Addr26, 2'b00});
    br_tgt    = pc_plus4 + (bus.BrOffset << 2);
    jr_tgt    = (bus.RetEn && !ras_empty) ? ras_top : bus.JrTarget;
    pop_miss  = ras_empty || (ras_top != bus.JrTarget);
  end

  // Push/pop only on the path actually selected, and never under Exc or Stall.
  always_comb begin
    advance = !bus.Stall && !bus.Exc;
    do_pop  = advance && bus.JrEn && bus.RetEn;
    do_push = advance && !bus.JrEn && bus.JumpEn && bus.LinkEn;
  end

  always_comb begin
    next_pc = pc_plus4;
    if (bus.Exc) begin
      next_pc = EXC_VECTOR;
    end else if (bus.JrEn) begin
      next_pc = jr_tgt;
    end else if (bus.JumpEn) begin
      next_pc = jump_tgt;
    end else if (bus.BrTaken) begin
      next_pc = br_tgt;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      pc_q      <= RESET_VECTOR;
      wr_ptr    <= '0;
      count     <= '0;
      ovf_q     <= 1'b0;
      retmiss_q <= 1'b0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        stack[i] <= '0;
      end
    end else begin
      if (bus.Exc || !bus.Stall) begin
        pc_q <= next_pc;
      end
      if (!bus.Stall) begin
        retmiss_q <= do_pop && pop_miss;
      end
      // When full, the write slot at wr_ptr is the oldest entry, so the
      // pointer simply keeps rotating and the count stays saturated.
      if (do_push) begin
        stack[wr_ptr] <= pc_plus8;
        wr_ptr        <= wr_ptr + PW'(1);
        if (ras_full) begin
          ovf_q <= 1'b1;
        end else begin
          count <= count + CW'(1);
        end
      end else if (do_pop && !ras_empty) begin
        wr_ptr <= top_idx;
        count  <= count - CW'(1);
      end
    end
  end

  assign bus.PC          = pc_q;
  assign bus.PCPlus4     = pc_plus4;
  assign bus.PCPlus8     = pc_plus8;
  assign bus.RasTop      = ras_top;
  assign bus.RasEmpty    = ras_empty;
  assign bus.RasOverflow = ovf_q;
  assign bus.RetMiss     = retmiss_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RV = 32'h0000_3000;
  localparam logic [31:0] EV = 32'h0000_4180;

  logic clk;
  logic rst_n;

  pc_sequencer_if #(.WIDTH(32)) bus ();

  pc_sequencer #(
    .WIDTH(32),
    .RESET_VECTOR(RV),
    .EXC_VECTOR(EV),
    .RAS_DEPTH(DEPTH)
  ) dut (
    .CLK(clk),
    .Reset(rst_n),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] top;
    logic        empty;
    logic        ovf;
    logic        miss;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          fails  = 0;

  // Reference model: the RAS is an unbounded queue trimmed from the front.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_ovf;
  logic        m_miss;

  task automatic clear_inputs();
    bus.Stall    = 1'b0;
    bus.Exc      = 1'b0;
    bus.BrTaken  = 1'b0;
    bus.BrOffset = '0;
    bus.JumpEn   = 1'b0;
    bus.Addr26   = '0;
    bus.LinkEn   = 1'b0;
    bus.JrEn     = 1'b0;
    bus.JrTarget = '0;
    bus.RetEn    = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] p4;
    logic [31:0] t;
    exp_t        e;
    p4 = m_pc + 32'd4;
    if (bus.Exc) begin
      m_pc = EV;
      if (!bus.Stall) m_miss = 1'b0;
    end else if (!bus.Stall) begin
      m_miss = 1'b0;
      if (bus.JrEn) begin
        if (bus.RetEn && m_ras.size() > 0) begin
          t      = m_ras.pop_back();
          m_miss = (t != bus.JrTarget);
          m_pc   = t;
        end else begin
          m_miss = bus.RetEn;
          m_pc   = bus.JrTarget;
        end
      end else if (bus.JumpEn) begin
        if (bus.LinkEn) begin
          if (m_ras.size() == DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
          m_ras.push_back(m_pc + 32'd8);
        end
        m_pc = {p4[31:28], bus.Addr26, 2'b00};
      end else if (bus.BrTaken) begin
        m_pc = p4 + (bus.BrOffset << 2);
      end else begin
        m_pc = p4;
      end
    end
    e.pc    = m_pc;
    e.top   = (m_ras.size() > 0) ? m_ras[$] : 32'h0;
    e.empty = (m_ras.size() == 0);
    e.ovf   = m_ovf;
    e.miss  = m_miss;
    sb.push_back(e);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard consumer: compares every clocked result 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.PC !== e.pc) begin
          fails++;
          $display("FAIL sb_pc got %h want %h at %0t", bus.PC, e.pc, $time);
        end
        checks++;
        if (bus.PCPlus4 !== e.pc + 32'd4 || bus.PCPlus8 !== e.pc + 32'd8) begin
          fails++;
          $display("FAIL sb_pcplus got %h/%h want %h/%h", bus.PCPlus4, bus.PCPlus8,
                   e.pc + 32'd4, e.pc + 32'd8);
        end
        checks++;
        if (bus.RasTop !== e.top) begin
          fails++;
          $display("FAIL sb_rastop got %h want %h at %0t", bus.RasTop, e.top, $time);
        end
        checks++;
        if (bus.RasEmpty !== e.empty || bus.RasOverflow !== e.ovf || bus.RetMiss !== e.miss) begin
          fails++;
          $display("FAIL sb_flags got empty=%b ovf=%b miss=%b want %b %b %b at %0t",
                   bus.RasEmpty, bus.RasOverflow, bus.RetMiss, e.empty, e.ovf, e.miss, $time);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.PC !== RV || bus.RasEmpty !== 1'b1 || bus.RasTop !== 32'h0 ||
        bus.RasOverflow !== 1'b0 || bus.RetMiss !== 1'b0) begin
      fails++;
      $display("FAIL async_reset got pc=%h empty=%b top=%h ovf=%b miss=%b want %h 1 0 0 0",
               bus.PC, bus.RasEmpty, bus.RasTop, bus.RasOverflow, bus.RetMiss, RV);
    end
    m_pc   = RV;
    m_ras.delete();
    m_ovf  = 1'b0;
    m_miss = 1'b0;
    @(posedge clk);
    #5;
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.PC !== RV) begin
      fails++;
      $display("FAIL reset_release got pc=%h want %h", bus.PC, RV);
    end
  endtask

  task automatic test_reset();
    logic [31:0] want [3];
    want = '{32'h3004, 32'h3008, 32'h300C};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.PC !== want[i] || bus.RasEmpty !== 1'b1) begin
        fails++;
        $display("FAIL idle_seq%0d got pc=%h empty=%b want %h 1", i, bus.PC, bus.RasEmpty, want[i]);
      end
    end
  endtask

  task automatic test_branch();
    step();
    checks++;
    if (bus.PC !== 32'h3010) begin
      fails++; $display("FAIL br_pre got %h want 00003010", bus.PC);
    end
    bus.BrTaken = 1'b1; bus.BrOffset = -32'sd2;
    step();
    checks++;
    if (bus.PC !== 32'h300C) begin
      fails++; $display("FAIL br_back got %h want 0000300c", bus.PC);
    end
    clear_inputs();
    step();
    bus.Stall = 1'b1; bus.BrTaken = 1'b1; bus.BrOffset = -32'sd2;
    step();
    checks++;
    if (bus.PC !== 32'h3010) begin
      fails++; $display("FAIL br_stall got %h want 00003010", bus.PC);
    end
    bus.Stall = 1'b0;
    step();
    checks++;
    if (bus.PC !== 32'h300C) begin
      fails++; $display("FAIL br_unstall got %h want 0000300c", bus.PC);
    end
    bus.BrOffset = 32'd3;
    step();
    checks++;
    if (bus.PC !== 32'h301C) begin
      fails++; $display("FAIL br_fwd got %h want 0000301c", bus.PC);
    end
    clear_inputs();
  endtask

  task automatic test_call_return();
    do_reset();
    bus.JumpEn = 1'b1; bus.LinkEn = 1'b1; bus.Addr26 = 26'h0000400;
    step();
    checks++;
    if (bus.PC !== 32'h1000 || bus.RasTop !== 32'h3008 || bus.RasEmpty !== 1'b0) begin
      fails++;
      $display("FAIL jal got pc=%h top=%h empty=%b want 00001000 00003008 0",
               bus.PC, bus.RasTop, bus.RasEmpty);
    end
    clear_inputs();
    bus.JrEn = 1'b1; bus.RetEn = 1'b1; bus.JrTarget = 32'h3008;
    step();
    checks++;
    if (bus.PC !== 32'h3008 || bus.RasEmpty !== 1'b1 || bus.RetMiss !== 1'b0) begin
      fails++;
      $display("FAIL ret got pc=%h empty=%b miss=%b want 00003008 1 0",
               bus.PC, bus.RasEmpty, bus.RetMiss);
    end
    clear_inputs();
    bus.LinkEn = 1'b1;
    step();
    checks++;
    if (bus.PC !== 32'h300C || bus.RasEmpty !== 1'b1) begin
      fails++; $display("FAIL link_alone got pc=%h empty=%b want 0000300c 1", bus.PC, bus.RasEmpty);
    end
    clear_inputs();
    bus.RetEn = 1'b1;
    step();
    checks++;
    if (bus.PC !== 32'h3010 || bus.RetMiss !== 1'b0) begin
      fails++; $display("FAIL ret_alone got pc=%h miss=%b want 00003010 0", bus.PC, bus.RetMiss);
    end
    clear_inputs();
  endtask

  task automatic test_overflow();
    logic [25:0] a26   [5];
    logic [31:0] jpc   [5];
    logic [31:0] jrt   [4];
    logic [31:0] ppc   [4];
    logic        pmiss [4];
    a26   = '{26'h400, 26'h800, 26'h1000, 26'h1400, 26'h1800};
    jpc   = '{32'h1000, 32'h2000, 32'h4000, 32'h5000, 32'h6000};
    jrt   = '{32'h5008, 32'h4008, 32'h100, 32'h100};
    ppc   = '{32'h5008, 32'h4008, 32'h2008, 32'h1008};
    pmiss = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      clear_inputs();
      bus.JumpEn = 1'b1; bus.LinkEn = 1'b1; bus.Addr26 = a26[i];
      step();
      checks++;
      if (bus.PC !== jpc[i] || bus.RasOverflow !== (i == 4)) begin
        fails++;
        $display("FAIL push%0d got pc=%h ovf=%b want %h %b", i, bus.PC, bus.RasOverflow, jpc[i], i == 4);
      end
    end
    checks++;
    if (bus.RasTop !== 32'h5008) begin
      fails++; $display("FAIL push_top got %h want 00005008", bus.RasTop);
    end
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      bus.JrEn = 1'b1; bus.RetEn = 1'b1; bus.JrTarget = jrt[i];
      step();
      checks++;
      if (bus.PC !== ppc[i] || bus.RetMiss !== pmiss[i]) begin
        fails++;
        $display("FAIL pop%0d got pc=%h miss=%b want %h %b", i, bus.PC, bus.RetMiss, ppc[i], pmiss[i]);
      end
      if (i == 2) begin
        clear_inputs();
        bus.Stall = 1'b1;
        step();
        checks++;
        if (bus.PC !== 32'h2008 || bus.RetMiss !== 1'b1) begin
          fails++;
          $display("FAIL stall_hold got pc=%h miss=%b want 00002008 1", bus.PC, bus.RetMiss);
        end
      end
    end
    clear_inputs();
    bus.JrEn = 1'b1; bus.RetEn = 1'b1; bus.JrTarget = 32'h7000;
    step();
    checks++;
    if (bus.PC !== 32'h7000 || bus.RetMiss !== 1'b1 || bus.RasEmpty !== 1'b1 || bus.RasOverflow !== 1'b1) begin
      fails++;
      $display("FAIL pop_empty got pc=%h miss=%b empty=%b ovf=%b want 00007000 1 1 1",
               bus.PC, bus.RetMiss, bus.RasEmpty, bus.RasOverflow);
    end
    clear_inputs();
  endtask

  task automatic test_exc();
    bus.JumpEn = 1'b1; bus.LinkEn = 1'b1; bus.Addr26 = 26'h200;
    step();
    clear_inputs();
    bus.Exc = 1'b1; bus.Stall = 1'b1; bus.JrEn = 1'b1; bus.RetEn = 1'b1; bus.JrTarget = 32'h7008;
    step();
    checks++;
    if (bus.PC !== EV || bus.RasTop !== 32'h7008 || bus.RasEmpty !== 1'b0) begin
      fails++;
      $display("FAIL exc got pc=%h top=%h empty=%b want %h 00007008 0", bus.PC, bus.RasTop, bus.RasEmpty, EV);
    end
    clear_inputs();
    bus.Exc = 1'b1; bus.JumpEn = 1'b1; bus.LinkEn = 1'b1;
    step();
    checks++;
    if (bus.PC !== EV || bus.RasTop !== 32'h7008) begin
      fails++; $display("FAIL exc_nopush got pc=%h top=%h want %h 00007008", bus.PC, bus.RasTop, EV);
    end
    clear_inputs();
    step();
    do_reset();
    step();
    checks++;
    if (bus.PC !== 32'h3004 || bus.RasEmpty !== 1'b1 || bus.RasOverflow !== 1'b0) begin
      fails++;
      $display("FAIL post_reset got pc=%h empty=%b ovf=%b want 00003004 1 0",
               bus.PC, bus.RasEmpty, bus.RasOverflow);
    end
  endtask

  task automatic test_wrap();
    clear_inputs();
    bus.JrEn = 1'b1; bus.JrTarget = 32'hFFFF_FFFC;
    step();
    clear_inputs();
    step();
    checks++;
    if (bus.PC !== 32'h0 || bus.RasOverflow !== 1'b0) begin
      fails++; $display("FAIL wrap_seq got pc=%h ovf=%b want 00000000 0", bus.PC, bus.RasOverflow);
    end
    bus.BrTaken = 1'b1; bus.BrOffset = -32'sd4;
    step();
    checks++;
    if (bus.PC !== 32'hFFFF_FFF4) begin
      fails++; $display("FAIL wrap_br got %h want fffffff4", bus.PC);
    end
    clear_inputs();
    bus.JrEn = 1'b1; bus.JrTarget = 32'h7FFF_FFF0;
    step();
    clear_inputs();
    bus.JumpEn = 1'b1; bus.Addr26 = 26'h3FF_FFFF;
    step();
    checks++;
    if (bus.PC !== 32'h7FFF_FFFC) begin
      fails++; $display("FAIL jump_hi got %h want 7ffffffc", bus.PC);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      clear_inputs();
      bus.Stall    = ($urandom_range(0, 4) == 0);
      bus.Exc      = ($urandom_range(0, 31) == 0);
      bus.BrTaken  = $urandom_range(0, 1);
      bus.BrOffset = 32'($signed($urandom_range(0, 64)) - 32);
      bus.JumpEn   = ($urandom_range(0, 2) == 0);
      bus.LinkEn   = $urandom_range(0, 1);
      bus.Addr26   = 26'($urandom);
      bus.JrEn     = ($urandom_range(0, 3) == 0);
      bus.RetEn    = ($urandom_range(0, 3) != 0);
      bus.JrTarget = {$urandom, 2'b00} & 32'h0000_FFFC;
      if (m_ras.size() > 0 && $urandom_range(0, 2) != 0) bus.JrTarget = m_ras[$];
      step();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b1;
    #3;
    test_reset();
    test_branch();
    test_call_return();
    test_overflow();
    test_exc();
    test_wrap();
    test_random();
    #20;
    checks++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL sb_drain got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, PC/address width (>=28).
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_3000, PC value after reset.
REQ-003 SHALL have parameter EXC_VECTOR, default 32'h0000_4180, exception entry address.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of 2, >=2).
REQ-005 SHALL have port CLK  in  1  clock, rising edge active.
REQ-006 SHALL have port Reset  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port Stall  in  1  hold PC and RAS this cycle.
REQ-008 SHALL have port Exc  in  1  redirect to EXC_VECTOR.
REQ-009 SHALL have port BrTaken  in  1  conditional branch taken.
REQ-010 SHALL have port BrOffset  in  WIDTH  sign-extended word offset (unshifted).
REQ-011 SHALL have port JumpEn  in  1  J-type jump.
REQ-012 SHALL have port Addr26  in  26  J-type target field.
REQ-013 SHALL have port LinkEn  in  1  jal: push link address onto RAS (qualifies JumpEn).
REQ-014 SHALL have port JrEn  in  1  register jump.
REQ-015 SHALL have port JrTarget  in  WIDTH  register-file jump target.
REQ-016 SHALL have port RetEn  in  1  jr is a return: pop RAS (qualifies JrEn).
REQ-017 SHALL have port PC  out  WIDTH  current PC (registered).
REQ-018 SHALL have port PCPlus4 / PCPlus8  out  WIDTH each  PC+4, PC+8 (combinational).
REQ-019 SHALL have port RasTop  out  WIDTH  top-of-stack value (0 when empty).
REQ-020 SHALL have ports RasEmpty  out  1, RasOverflow  out  1 (sticky), RetMiss  out  1 (registered, one-cycle pulse).

Function
REQ-021 SHALL compute next PC with priority Exc > JrEn > JumpEn > BrTaken > sequential.
REQ-022 Targets SHALL be: EXC_VECTOR; return target; {PCPlus4[WIDTH-1:28], Addr26, 2'b00}; PCPlus4 + (BrOffset<<2); PCPlus4.
REQ-023 Return target SHALL be RasTop when JrEn&RetEn&!RasEmpty, else JrTarget.
REQ-024 All additions SHALL be modulo 2^WIDTH; wrap-around is not flagged.
REQ-025 PC SHALL update on every rising CLK when Stall=0; when Stall=1 PC, RAS and RetMiss SHALL hold, except Exc=1 SHALL load EXC_VECTOR regardless of Stall.
REQ-026 Push (JumpEn&LinkEn, selected path, not stalled) SHALL write PCPlus8 at the top; count increments, saturating at RAS_DEPTH.
REQ-027 Push when count==RAS_DEPTH SHALL overwrite the oldest entry (circular) and set RasOverflow=1 until reset.
REQ-028 Pop (JrEn&RetEn, selected path, not stalled) SHALL decrement count; pop when empty SHALL leave count at 0.
REQ-029 RetMiss SHALL pulse the cycle after a pop where RasEmpty=1 or RasTop!=JrTarget; PC SHALL still take RasTop when non-empty (JrTarget when empty).
REQ-030 Exc SHALL suppress any push/pop in the same cycle; RAS contents SHALL be preserved.
REQ-031 Push and pop SHALL never coincide (JrEn outranks JumpEn); LinkEn without JumpEn and RetEn without JrEn SHALL be ignored.
REQ-032 Latency: control inputs sampled at edge n SHALL be visible on PC/RasTop/RasEmpty after edge n.

Reset
REQ-033 Reset=0 SHALL immediately force PC=RESET_VECTOR, RAS count=0, pointers=0, RasEmpty=1, RasTop=0, RasOverflow=0, RetMiss=0, independent of CLK.
REQ-034 Reset asserted mid-operation SHALL discard all RAS contents; deassertion SHALL take effect at the next rising CLK without glitching PC.

Verification
REQ-035 Reset then 3 idle clocks -> PC 0x3000, 0x3004, 0x3008, 0x300C; RasEmpty=1.
REQ-036 PC=0x3010, BrTaken=1, BrOffset=-2 -> PC=0x300C; with Stall=1 same stimulus -> PC stays 0x3010.
REQ-037 PC=0x3000, JumpEn=LinkEn=1, Addr26=0x0000400 -> PC=0x1000, RasTop=0x3008; then JrEn=RetEn=1, JrTarget=0x3008 -> PC=0x3008, RasEmpty=1, RetMiss=0.
REQ-038 5 jal pushes with RAS_DEPTH=4 -> RasOverflow=1, 4 pops return last four link addresses in LIFO order, 5th pop uses JrTarget and RetMiss=1.
REQ-039 Exc=1 together with Stall=1, JrEn=RetEn=1 -> PC=0x4180, RAS count unchanged; Reset pulse mid-stream -> PC=0x3000 asynchronously, RasOverflow=0.
REQ-040 WIDTH=32, PC=0xFFFFFFFC, sequential -> PC=0x00000000, no flag.
